// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory and decoder handshake bundle for fetch_unit
interface fetch_if #(
  parameter int ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [15:0]       imem_rdata;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        pc_sel;
  logic [15:0]       target;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_valid, imem_rdata, instr_ready, pc_sel, target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_valid, imem_rdata, instr_ready, pc_sel, target
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch and PC sequencer with return stack
module fetch_unit #(
  parameter int          ADDR_W    = 10,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  fetch_if.master                        bus,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W-1:0];

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_top;   // next free slot; top entry lives at ras_top-1
  logic [PTR_W-1:0]  ras_top_m1;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              do_push;
  logic              do_pop;
  logic              pop_empty;
  logic              ras_full;
  logic              handshake;

  // Only the low ADDR_W bits of the decoder immediate form an address.
  logic unused_target_hi;
  assign unused_target_hi = ^bus.target[15:ADDR_W];

  // Next-PC selection from the decoder response for the held instruction.
  always_comb begin
    pc_inc     = pc + ADDR_W'(1);
    ras_top_m1 = ras_top - PTR_W'(1);
    ras_full   = (ras_count == CNT_W'(RAS_DEPTH));
    handshake  = (state == S_ISSUE) && bus.instr_ready;
    next_pc    = pc_inc;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    pop_empty  = 1'b0;
    case (bus.pc_sel)
      2'b00: next_pc = pc_inc;
      2'b01: next_pc = bus.target[ADDR_W-1:0];
      2'b10: begin
        next_pc = bus.target[ADDR_W-1:0];
        do_push = 1'b1;
      end
      2'b11: begin
        if (ras_count == '0) begin
          next_pc   = pc_inc;
          pop_empty = 1'b1;
        end else begin
          next_pc = ras_mem[ras_top_m1];
          do_pop  = 1'b1;
        end
      end
    endcase
  end

  // Return-stack storage; a push when full lands on the oldest slot because the pointer wraps.
  always_ff @(posedge clk) begin
    if (rst_n && handshake && do_push) begin
      ras_mem[ras_top] <= pc_inc;
    end
  end

  // Fetch/issue sequencer with registered memory request and decoder-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_FETCH;
      pc              <= RESET_ADDR;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_ADDR;
      bus.instr       <= 16'h0000;
      bus.instr_valid <= 1'b0;
      ras_top         <= '0;
      ras_count       <= '0;
      ras_overflow    <= 1'b0;
      ras_underflow   <= 1'b0;
    end else begin
      case (state)
        // Request is normally raised by the handshake that enters FETCH; only right
        // after reset does FETCH arrive with it low and need to raise it itself.
        S_FETCH: begin
          if (bus.imem_req) begin
            bus.imem_req <= 1'b0;
            state        <= S_WAIT;
          end else begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
          end
        end
        S_WAIT: begin
          if (bus.imem_valid) begin
            bus.instr       <= bus.imem_rdata;
            bus.instr_valid <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            pc              <= next_pc;
            bus.imem_req    <= 1'b1;
            bus.imem_addr   <= next_pc;
            state           <= S_FETCH;
            if (do_push) begin
              ras_top <= ras_top + PTR_W'(1);
              if (ras_full) begin
                ras_overflow <= 1'b1;
              end else begin
                ras_count <= ras_count + CNT_W'(1);
              end
            end
            if (do_pop) begin
              ras_top   <= ras_top_m1;
              ras_count <= ras_count - CNT_W'(1);
            end
            if (pop_empty) begin
              ras_underflow <= 1'b1;
            end
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  logic       clk;
  logic       rst_n;
  logic [9:0] pc;
  logic [2:0] ras_count;
  logic       ras_overflow;
  logic       ras_underflow;

  fetch_if #(.ADDR_W(10)) bus ();

  fetch_unit #(.ADDR_W(10), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .pc            (pc),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // decoder stand-in: [15:14] select, [9:0] address, [13:10] junk the DUT must drop
  assign bus.pc_sel = bus.instr[15:14];
  assign bus.target = {2'b00, bus.instr[13:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  int          mem_lat;
  logic        stale_ok;
  int          checks;
  int          errors;

  // model state
  logic [9:0]  m_pc;
  logic        m_ovf;
  logic        m_unf;
  int          ras_q[$];
  logic        live;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: answers each request after mem_lat cycles; can inject stale data words
  initial begin : memory
    int         pend;
    logic [9:0] paddr;
    pend = 0;
    paddr = '0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      bus.imem_valid = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = mem[paddr];
        end
      end
      if (stale_ok) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'hDEAD;
      end
      if (rst_n && bus.imem_req) begin
        pend = mem_lat;
        paddr = bus.imem_addr;
      end
    end
  end

  // architectural model and per-cycle comparison
  initial begin : model
    logic [15:0] w;
    logic [9:0]  inc;
    live = 1'b0;
    m_pc = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    forever begin
      @(negedge clk);
      if (live) begin
        check("m_pc", pc, m_pc);
        check("m_ras_count", ras_count, ras_q.size());
        check("m_ovf", ras_overflow, m_ovf);
        check("m_unf", ras_underflow, m_unf);
        if (bus.imem_req) begin
          check("m_imem_addr", bus.imem_addr, m_pc);
          check("m_req_while_valid", bus.instr_valid, 1'b0);
        end
        if (bus.instr_valid) check("m_instr", bus.instr, mem[m_pc]);
      end
      if (!rst_n) begin
        m_pc = 10'd0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        ras_q.delete();
        live = 1'b1;
      end else if (live && bus.instr_valid && bus.instr_ready) begin
        w = mem[m_pc];
        inc = m_pc + 10'd1;
        case (w[15:14])
          2'b00: m_pc = inc;
          2'b01: m_pc = w[9:0];
          2'b10: begin
            if (ras_q.size() == 4) begin
              void'(ras_q.pop_front());
              m_ovf = 1'b1;
            end
            ras_q.push_back(int'(inc));
            m_pc = w[9:0];
          end
          default: begin
            if (ras_q.size() == 0) begin
              m_pc = inc;
              m_unf = 1'b1;
            end else m_pc = 10'(ras_q.pop_back());
          end
        endcase
      end
    end
  end

  task automatic wait_req(output logic [9:0] a, input string name);
    bit got;
    got = 1'b0;
    a = '0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        a = bus.imem_addr;
        got = 1'b1;
      end
    end
    if (!got) check(name, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [9:0] a;
    int         rc[$];
    int         ra[$];
    int         exp_c[4];
    int         exp_a[11];
    bit         got;
    exp_c = '{1, 4, 7, 10};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    stale_ok = 1'b0;
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h2800;
    mem[4] = 16'h2955;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_imem_addr", bus.imem_addr, 10'h000);
    check("rst_instr", bus.instr, 16'h0000);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_pc", pc, 10'h000);
    check("rst_ras_count", ras_count, 3'd0);
    check("rst_ovf", ras_overflow, 1'b0);
    check("rst_unf", ras_underflow, 1'b0);

    // sequential run: requests at cycles 1,4,7,10 to 0..3
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        rc.push_back(i);
        ra.push_back(int'(bus.imem_addr));
      end
    end
    check("seq_req_count", rc.size(), 4);
    for (int i = 0; i < 4 && i < rc.size(); i++) begin
      check("seq_req_cycle", rc[i], exp_c[i]);
      check("seq_req_addr", ra[i], i);
    end

    // backpressure on the word at 4
    wait_req(a, "bp_req4_timeout");
    check("bp_req4", a, 10'd4);
    @(posedge clk);
    #1 bus.instr_ready = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.instr_valid;
    end
    check("bp_valid_seen", got, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_instr", bus.instr, 16'h2955);
      check("bp_pc", pc, 10'd4);
      check("bp_no_req", bus.imem_req, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.instr_ready = 1'b1;
    wait_req(a, "bp_next_timeout");
    check("bp_next_addr", a, 10'd5);

    // branch to 0x3FF then wrap
    do_reset();
    mem[0] = 16'h6BFF;
    mem[10'h3FF] = 16'h2800;
    rst_n = 1'b1;
    wait_req(a, "br_t0");
    check("br_a0", a, 10'h000);
    wait_req(a, "br_t1");
    check("br_a1", a, 10'h3FF);
    wait_req(a, "br_t2");
    check("br_wrap", a, 10'h000);

    // call at 5 to 0x40, return to 6
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 16'h2800;
    mem[5] = 16'hA840;
    mem[6] = 16'h2800;
    mem[10'h040] = 16'hE800;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_req(a, "call_t");
      check("call_seq", a, 10'(i));
    end
    wait_req(a, "call_tj");
    check("call_target", a, 10'h040);
    check("call_count", ras_count, 3'd1);
    wait_req(a, "call_tr");
    check("ret_addr", a, 10'h006);
    check("ret_count", ras_count, 3'd0);

    // nested calls beyond stack depth, then unwinding past empty
    mem_lat = 2;
    do_reset();
    mem[10'h000] = 16'hA810;
    mem[10'h010] = 16'hA820;
    mem[10'h020] = 16'hA830;
    mem[10'h030] = 16'hA840;
    mem[10'h040] = 16'hA850;
    mem[10'h050] = 16'hE800;
    mem[10'h041] = 16'hE800;
    mem[10'h031] = 16'hE800;
    mem[10'h021] = 16'hE800;
    mem[10'h011] = 16'hE800;
    mem[10'h012] = 16'h2800;
    exp_a = '{'h000, 'h010, 'h020, 'h030, 'h040, 'h050, 'h041, 'h031, 'h021, 'h011, 'h012};
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_req(a, "ras_t");
      check("ras_seq", a, exp_a[i]);
      if (i == 5) begin
        check("ras_ovf_set", ras_overflow, 1'b1);
        check("ras_full_count", ras_count, 3'd4);
        check("ras_unf_clear", ras_underflow, 1'b0);
      end
      if (i == 10) begin
        check("ras_unf_set", ras_underflow, 1'b1);
        check("ras_empty_count", ras_count, 3'd0);
      end
    end

    // reset during WAIT, stale data after release
    mem_lat = 4;
    do_reset();
    mem[0] = 16'h2800;
    mem[1] = 16'h2800;
    rst_n = 1'b1;
    wait_req(a, "rmid_t0");
    check("rmid_first", a, 10'h000);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale_ok = 1'b1;
    @(posedge clk);
    #1;
    wait_req(a, "rmid_t1");
    check("rmid_req_addr", a, 10'h000);
    check("rmid_ovf", ras_overflow, 1'b0);
    check("rmid_unf", ras_underflow, 1'b0);
    check("rmid_no_valid", bus.instr_valid, 1'b0);
    @(posedge clk);
    #1 stale_ok = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.instr_valid;
    end
    check("rmid_valid_seen", got, 1'b1);
    check("rmid_instr", bus.instr, 16'h2800);
    check("rmid_pc", pc, 10'h000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
